tmds_encoder: RTL
=================

# tmds_encoder

- Upstream neighbour of the serializer: converts one 8-bit pixel channel plus control/aux symbols into 10-bit TMDS characters per DVI 1.0 / HDMI 1.4 rules.
- Two-stage pipeline with running-disparity (DC balance) tracking.
- Emits one character per pixelClk, for the shift-register serializer to load.
- Three instances (blue/green/red) form the HDMI transmit path.

## Interface
- dispWidth, 5: signed running-disparity register width. Must be ≥5 to hold −8..+8.
- pixelClk  in  1  pixel clock. All logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- videoEnable  in  1  1 = active video: encode dataIn with 8b/10b TMDS.
- dataIn  in  8  pixel byte.
- ctrl  in  2  control bits {C1,C0}, used during blanking.
- dataIsland  in  1  1 = data-island period: encode auxData with TERC4 (see Configuration).
- auxData  in  4  TERC4 nibble.
- tmdsOut  out  10  encoded character. Bit 0 is first on the wire.
- tmdsValid  out  1  tmdsOut holds a character derived from post-reset inputs.
- disparity  out  dispWidth  current running disparity, two's complement (debug/verification).

## Operation
- Mode priority, sampled at stage 1: videoEnable > dataIsland > control.
- Stage 1 (registered):
  - Capture the mode and the ctrl/auxData inputs.
  - Compute N1(dataIn).
  - If N1>4, or N1==4 and dataIn[0]==0: XNOR chain, q_m[0]=D[0], q_m[i]=~(q_m[i−1]^D[i]), q_m[8]=0.
  - Otherwise: XOR chain, q_m[8]=1.
- Stage 2 (registered), video mode. N1/N0 count over q_m[7:0]; cnt is the disparity register.
  - Case A, cnt==0 or N1==N0:
    - out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += q_m[8] ? (N1−N0) : (N0−N1).
  - Case B, (cnt>0 and N1>N0) or (cnt<0 and N0>N1):
    - out = {1, q_m[8], ~q_m[7:0]}.
    - cnt += 2·q_m[8] + (N0−N1).
  - Case C, otherwise:
    - out = {0, q_m[8], q_m[7:0]}.
    - cnt += −2·(~q_m[8]) + (N1−N0).
- Control mode:
  - ctrl 00 → 0x354 (1101010100).
  - ctrl 01 → 0x0AB (0010101011).
  - ctrl 10 → 0x154 (0101010100).
  - ctrl 11 → 0x2AB (1010101011).
  - cnt cleared to 0.
- Arithmetic: all cnt math in signed dispWidth bits. Valid encoder input never drives it outside −8..+8, so no saturation logic.
- Mode switch: a video character following blanking always starts from cnt=0.

## Timing
- Latency: exactly 2 pixelClk edges from input sample to tmdsOut.
- Throughput: one character per cycle, no stalls, no backpressure.
- Reset values (all outputs): tmdsOut=0x000, tmdsValid=0, disparity=0. Both pipeline stages are cleared.
- After reset deasserts, tmdsValid rises on the 2nd rising edge and stays high until the next reset.
- Reset asserted mid-stream: the next edge clears everything, and in-flight characters are discarded. There is no partial-state carryover.
- Simultaneous videoEnable and dataIsland: video wins, and the disparity update follows video rules.
- Serializer handoff: tmdsOut is stable for the full pixelClk period. The downstream serializer must load it once per pixel and shift bit 0 first.

## Configuration
- TMDS_TERC4_EN defined:
  - dataIsland selects TERC4 per the HDMI 1.4a table, e.g. 0x0→0x29C (1010011100), 0xF→0x2C3 (1011000011).
  - cnt is cleared during data-island characters.
- TMDS_TERC4_EN undefined:
  - dataIsland and auxData are ignored; the ports remain.
  - Non-video cycles always emit control codes. DVI-only build.

## Test plan
- Reset for 3 cycles, release, dataIn held at 0x00 with videoEnable=1:
  - tmdsValid rises on the 2nd edge.
  - tmdsOut sequence 0x100, 0x3FF, 0x100.
  - disparity −8, +2, −6.
- From cnt=0, dataIn=0xFF with videoEnable=1 → tmdsOut=0x200 (XNOR path, q_m[8]=0), disparity=−8.
- Blanking sweep over ctrl=00/01/10/11 → 0x354/0x0AB/0x154/0x2AB, each 2 cycles after input; disparity=0 throughout.
- Reset asserted one cycle into a video burst:
  - Next edge gives tmdsOut=0, tmdsValid=0, disparity=0.
  - Post-release output matches a fresh run.
- With TMDS_TERC4_EN: dataIsland=1, auxData=0x0 then 0xF → 0x29C, 0x2C3.
- With TMDS_TERC4_EN: assert videoEnable and dataIsland together → video encoding wins.
- Random 10k pixels compared against a reference model:
  - exact tmdsOut match.
  - |disparity| ≤ 8 always.
  - The decoded 10b→8b result equals dataIn.

Source files
------------

// File: rtl/tmds_encoder.sv
`default_nettype none
// ============================================================================
// Module  : tmds_encoder
// Brief   : Two-stage DVI/HDMI TMDS channel encoder with running-disparity
//           tracking. Define TMDS_TERC4_EN for HDMI TERC4 data-island symbols.
// Revision: 1.0  initial release
// ============================================================================
module tmds_encoder #(
  parameter int dispWidth = 5
) (
  input  logic                        pixelClk,
  input  logic                        reset,
  input  logic                        videoEnable,
  input  logic [7:0]                  dataIn,
  input  logic [1:0]                  ctrl,
  input  logic                        dataIsland,
  input  logic [3:0]                  auxData,
  output logic [9:0]                  tmdsOut,
  output logic                        tmdsValid,
  output logic signed [dispWidth-1:0] disparity
);

  typedef enum logic [1:0] {
    MODE_CTRL  = 2'd0,
    MODE_VIDEO = 2'd1,
    MODE_TERC4 = 2'd2
  } mode_t;

  localparam logic [9:0] c_CTRL_00 = 10'h354;
  localparam logic [9:0] c_CTRL_01 = 10'h0AB;
  localparam logic [9:0] c_CTRL_10 = 10'h154;
  localparam logic [9:0] c_CTRL_11 = 10'h2AB;

  localparam logic signed [dispWidth-1:0] c_ZERO  = '0;
  localparam logic signed [dispWidth-1:0] c_TWO   = dispWidth'(2);
  localparam logic signed [dispWidth-1:0] c_EIGHT = dispWidth'(8);

  // ---------------------------------------------------------------- stage 1
  logic [3:0] w_dataOnes;
  logic       w_useXnor;
  logic [8:0] w_qm;
  mode_t      w_mode;

  mode_t      r_mode;
  logic [8:0] r_qm;
  logic [1:0] r_ctrl;
  logic       r_valid1;

  always_comb begin
    w_dataOnes = '0;
    for (int i = 0; i < 8; i++) begin
      w_dataOnes = w_dataOnes + 4'(dataIn[i]);
    end
    // Transition minimisation: XNOR when the byte is ones-heavy
    w_useXnor = (w_dataOnes > 4'd4) || ((w_dataOnes == 4'd4) && !dataIn[0]);
    w_qm      = '0;
    w_qm[0]   = dataIn[0];
    for (int i = 1; i < 8; i++) begin
      w_qm[i] = w_useXnor ? ~(w_qm[i-1] ^ dataIn[i]) : (w_qm[i-1] ^ dataIn[i]);
    end
    w_qm[8] = ~w_useXnor;
`ifdef TMDS_TERC4_EN
    if (videoEnable) begin
      w_mode = MODE_VIDEO;
    end else if (dataIsland) begin
      w_mode = MODE_TERC4;
    end else begin
      w_mode = MODE_CTRL;
    end
`else
    w_mode = videoEnable ? MODE_VIDEO : MODE_CTRL;
`endif
  end

`ifdef TMDS_TERC4_EN
  logic [3:0] r_aux;

  always_ff @(posedge pixelClk) begin
    if (reset) begin
      r_aux <= '0;
    end else begin
      r_aux <= auxData;
    end
  end

  function automatic logic [9:0] terc4(input logic [3:0] nib);
    logic [9:0] code;
    case (nib)
      4'h0:    code = 10'b1010011100;
      4'h1:    code = 10'b1001100011;
      4'h2:    code = 10'b1011100100;
      4'h3:    code = 10'b1011100010;
      4'h4:    code = 10'b0101110001;
      4'h5:    code = 10'b0100011110;
      4'h6:    code = 10'b0110001110;
      4'h7:    code = 10'b0100111100;
      4'h8:    code = 10'b1011001100;
      4'h9:    code = 10'b0100111001;
      4'hA:    code = 10'b0110011100;
      4'hB:    code = 10'b1011000110;
      4'hC:    code = 10'b1010001110;
      4'hD:    code = 10'b1001110001;
      4'hE:    code = 10'b0101100011;
      default: code = 10'b1011000011;
    endcase
    return code;
  endfunction
`else
  logic w_unused;
  assign w_unused = ^{dataIsland, auxData};
`endif

  always_ff @(posedge pixelClk) begin
    if (reset) begin
      r_mode   <= MODE_CTRL;
      r_qm     <= '0;
      r_ctrl   <= '0;
      r_valid1 <= 1'b0;
    end else begin
      r_mode   <= w_mode;
      r_qm     <= w_qm;
      r_ctrl   <= ctrl;
      r_valid1 <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [3:0]                  w_qmOnes;
  logic signed [dispWidth-1:0] w_diff;
  logic                        w_cntPos;
  logic                        w_cntNeg;
  logic                        w_diffPos;
  logic                        w_diffNeg;
  logic [9:0]                  w_nextOut;
  logic signed [dispWidth-1:0] w_nextCnt;

  logic [9:0]                  r_tmdsOut;
  logic signed [dispWidth-1:0] r_cnt;
  logic                        r_valid2;

  always_comb begin
    w_qmOnes = '0;
    for (int i = 0; i < 8; i++) begin
      w_qmOnes = w_qmOnes + 4'(r_qm[i]);
    end
    // N1 - N0 over q_m[7:0] equals 2*N1 - 8
    w_diff    = $signed(dispWidth'({w_qmOnes, 1'b0})) - c_EIGHT;
    w_cntNeg  = r_cnt[dispWidth-1];
    w_cntPos  = !w_cntNeg && (r_cnt != c_ZERO);
    w_diffNeg = w_diff[dispWidth-1];
    w_diffPos = !w_diffNeg && (w_diff != c_ZERO);
    w_nextOut = '0;
    w_nextCnt = c_ZERO;
    case (r_mode)
      MODE_VIDEO: begin
        if ((r_cnt == c_ZERO) || (w_diff == c_ZERO)) begin
          w_nextOut = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
          w_nextCnt = r_qm[8] ? (r_cnt + w_diff) : (r_cnt - w_diff);
        end else if ((w_cntPos && w_diffPos) || (w_cntNeg && w_diffNeg)) begin
          w_nextOut = {1'b1, r_qm[8], ~r_qm[7:0]};
          w_nextCnt = r_cnt + (r_qm[8] ? c_TWO : c_ZERO) - w_diff;
        end else begin
          w_nextOut = {1'b0, r_qm[8], r_qm[7:0]};
          w_nextCnt = r_cnt - (r_qm[8] ? c_ZERO : c_TWO) + w_diff;
        end
      end
`ifdef TMDS_TERC4_EN
      MODE_TERC4: begin
        w_nextOut = terc4(r_aux);
        w_nextCnt = c_ZERO;
      end
`endif
      default: begin
        case (r_ctrl)
          2'b00:   w_nextOut = c_CTRL_00;
          2'b01:   w_nextOut = c_CTRL_01;
          2'b10:   w_nextOut = c_CTRL_10;
          default: w_nextOut = c_CTRL_11;
        endcase
        w_nextCnt = c_ZERO;
      end
    endcase
  end

  // Stage 1 still holding reset contents yields no character.
  always_ff @(posedge pixelClk) begin
    if (reset || !r_valid1) begin
      r_tmdsOut <= '0;
      r_cnt     <= c_ZERO;
      r_valid2  <= 1'b0;
    end else begin
      r_tmdsOut <= w_nextOut;
      r_cnt     <= w_nextCnt;
      r_valid2  <= 1'b1;
    end
  end

  assign tmdsOut   = r_tmdsOut;
  assign tmdsValid = r_valid2;
  assign disparity = r_cnt;

endmodule
`default_nettype wire
